// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
//
// Purpose:
//   Fetch/dispatch controller that walks a program of 19-bit instruction words
//   held in an external instruction RAM. Each word is fetched, captured into
//   the instruction register and dispatched either as a load/store request to
//   the memory interface or as a start/opcode to the ALU. Each request is held
//   until its matching done, then the instruction retires and pc advances. The
//   run ends when the latched program length has been executed.
//
// Instruction word layout (ir):
//   [18:15] opcode (alu_opcode_t encoding, see OP_* below)
//   [14:1]  memory address
//   [0]     destination register select (0 = A, 1 = B)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   run        in   start pulse, honoured only when idle
//   prog_len   in   number of instructions to execute, sampled on run accept
//   imem_rd    out  instruction RAM read strobe
//   imem_addr  out  instruction RAM address (= pc)
//   imem_data  in   instruction word, valid one cycle after imem_rd
//   mem_load   out  load request (level, held until mem_done)
//   mem_store  out  store request (level, held until mem_done)
//   mem_addr   out  memory address from ir[14:1]
//   mem_sel_b  out  destination select from ir[0]
//   mem_done   in   memory interface done
//   alu_start  out  ALU start (level, held until alu_done)
//   alu_op     out  ALU opcode from ir[18:15]
//   alu_done   in   ALU done
//   busy       out  high from run accept until the finish cycle
//   finished   out  one-cycle pulse when the program completes or aborts
//   error      out  sticky watchdog abort flag, cleared by the next run
//   pc         out  program counter
//   retired    out  retired instruction count, saturating
//
// Build option:
//   SEQ_WATCHDOG_EN - when defined, a per-request cycle counter aborts a
//   request that sees no done within WD_LIMIT wait cycles; the program then
//   finishes with error set. When undefined, requests wait indefinitely and
//   error is constant 0.
// -----------------------------------------------------------------------------
module program_sequencer #(
    parameter int IMEM_AW  = 10,
    parameter int WD_LIMIT = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic [IMEM_AW:0]   prog_len,
    output logic               imem_rd,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [18:0]        imem_data,
    output logic               mem_load,
    output logic               mem_store,
    output logic [13:0]        mem_addr,
    output logic               mem_sel_b,
    input  logic               mem_done,
    output logic               alu_start,
    output logic [3:0]         alu_op,
    input  logic               alu_done,
    output logic               busy,
    output logic               finished,
    output logic               error,
    output logic [IMEM_AW-1:0] pc,
    output logic [15:0]        retired
);

    // alu_opcode_t values that the sequencer treats specially; every other
    // opcode is forwarded to the ALU.
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPT,
        S_ISSUE,
        S_WAIT_MEM,
        S_WAIT_ALU,
        S_FIN
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [18:0]        r_ir;
    logic [IMEM_AW:0]   r_len;
    logic [IMEM_AW-1:0] r_pc;
    logic [15:0]        r_retired;
    logic               r_error;
    logic               r_mem_load;
    logic               r_mem_store;
    logic               r_alu_start;

    logic               w_accept;
    logic               w_retire;
    logic               w_timeout;
    logic               w_last;
    logic [IMEM_AW:0]   w_pc_inc;
    logic [3:0]         w_op;

    assign w_op     = r_ir[18:15];
    // pc+1 is formed one bit wider so a length of 2^IMEM_AW is reachable
    // while pc itself wraps to 0.
    assign w_pc_inc = {1'b0, r_pc} + (IMEM_AW+1)'(1);
    assign w_last   = (w_pc_inc == r_len);

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] r_wd;

    // Counts cycles spent in a wait state; it is zero in every other state,
    // so it always starts from zero on entry to WAIT_MEM/WAIT_ALU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd <= '0;
        end else if (r_state == S_WAIT_MEM || r_state == S_WAIT_ALU) begin
            r_wd <= r_wd + WD_W'(1);
        end else begin
            r_wd <= '0;
        end
    end

    // A done arriving on the final allowed cycle still wins over the abort.
    assign w_timeout = (r_wd == WD_W'(WD_LIMIT - 1)) &&
                       ((r_state == S_WAIT_MEM && !mem_done) ||
                        (r_state == S_WAIT_ALU && !alu_done));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control strobes
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_accept     = 1'b1;
                    w_next_state = (prog_len == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: w_next_state = S_CAPT;
            S_CAPT:  w_next_state = S_ISSUE;
            S_ISSUE: begin
                case (w_op)
                    OP_LOAD, OP_STORE: w_next_state = S_WAIT_MEM;
                    OP_NOP:            w_retire     = 1'b1;
                    default:           w_next_state = S_WAIT_ALU;
                endcase
            end
            S_WAIT_MEM: begin
                if (mem_done) begin
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = S_FIN;
                end
            end
            S_WAIT_ALU: begin
                if (alu_done) begin
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = S_FIN;
                end
            end
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (w_retire) begin
            w_next_state = w_last ? S_FIN : S_FETCH;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir        <= '0;
            r_len       <= '0;
            r_pc        <= '0;
            r_retired   <= '0;
            r_error     <= 1'b0;
            r_mem_load  <= 1'b0;
            r_mem_store <= 1'b0;
            r_alu_start <= 1'b0;
        end else begin
            // Requests follow the state we are entering: they rise on the
            // ISSUE edge and fall on the edge that leaves the wait state.
            r_mem_load  <= (w_next_state == S_WAIT_MEM) && (w_op == OP_LOAD);
            r_mem_store <= (w_next_state == S_WAIT_MEM) && (w_op == OP_STORE);
            r_alu_start <= (w_next_state == S_WAIT_ALU);

            if (r_state == S_CAPT) begin
                r_ir <= imem_data;
            end

            if (w_accept) begin
                r_len     <= prog_len;
                r_pc      <= '0;
                r_retired <= '0;
                r_error   <= 1'b0;
            end else begin
                if (w_retire) begin
                    r_pc <= r_pc + IMEM_AW'(1);
                    if (r_retired != 16'hFFFF) begin
                        r_retired <= r_retired + 16'd1;
                    end
                end
                if (w_timeout) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    assign imem_rd   = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign mem_load  = r_mem_load;
    assign mem_store = r_mem_store;
    assign mem_addr  = r_ir[14:1];
    assign mem_sel_b = r_ir[0];
    assign alu_start = r_alu_start;
    assign alu_op    = w_op;
    assign busy      = (r_state != S_IDLE) && (r_state != S_FIN);
    assign finished  = (r_state == S_FIN);
    assign error     = r_error;
    assign pc        = r_pc;
    assign retired   = r_retired;

endmodule
